mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sits directly downstream of icache and dcache, between both caches and the
//  single-ported RAM. Arbitrates iREN against dREN/dWEN and forwards the winner's
//  address, store data and read data. Produces the iwait/iload (and dwait/dload)
//  handshake the caches consume. Registered grant FSM; dcache has priority by default.
// PARAMETERS
//  WORD_W      32  data/address width (word_t)
//  FAIR_LIMIT  4   consecutive D grants allowed while iREN pending (ARB_FAIR_EN only)
// PORTS
//  CLK       in   1       clock, all state on posedge
//  RST       in   1       asynchronous reset, active-high
//  iREN      in   1       icache read request
//  iaddr     in   WORD_W  icache word address
//  iwait     out  1       1 = icache request not yet complete
//  iload     out  WORD_W  instruction word to icache
//  dREN      in   1       dcache read request
//  dWEN      in   1       dcache write request (dREN&dWEN: write wins)
//  daddr     in   WORD_W  dcache address
//  dstore    in   WORD_W  dcache write data
//  dwait     out  1       1 = dcache request not yet complete
//  dload     out  WORD_W  data word to dcache
//  ramREN    out  1       RAM read enable
//  ramWEN    out  1       RAM write enable
//  ramaddr   out  WORD_W  RAM address
//  ramstore  out  WORD_W  RAM write data
//  ramload   in   WORD_W  RAM read data, valid when ramstate==ACCESS
//  ramstate  in   2       FREE=0, BUSY=1, ACCESS=2, ERROR=3
// BEHAVIOUR
//  Reset (async, RST=1): state=IDLE, fair_cnt=0; all outputs then take their IDLE
//   values: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
//  States: IDLE, IGRANT, DGRANT (registered). RAM side is driven only in *GRANT.
//  IDLE: dREN|dWEN -> DGRANT; else iREN -> IGRANT; else stay. No RAM access.
//  DGRANT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN.
//   ramstate==ACCESS: dwait=0 for that cycle, dload=ramload, next=IDLE.
//   BUSY/FREE/ERROR: dwait=1, hold state (ERROR = retry, no abort).
//   dREN=dWEN=0 (request withdrawn): RAM enables drop same cycle, next=IDLE.
//  IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0; ACCESS -> iwait=0, iload=ramload,
//   next=IDLE; iREN=0 -> abort to IDLE; otherwise hold with iwait=1.
//  Requester not granted always sees wait=1, load=0.
//  Minimum latency: request at cycle N -> grant N+1 -> earliest wait=0 at N+1
//   (RAM ACCESS in first granted cycle). Each completion returns through IDLE,
//   so back-to-back requests cost one IDLE bubble.
//  Grant is never preempted mid-transaction; a dcache request arriving during
//   IGRANT waits until IGRANT completes or aborts.
//  Request inputs sampled only in IDLE; addr/data changes in *GRANT pass through
//   combinationally (cache must hold them stable; not checked).
//  RST asserted mid-transaction: immediate return to IDLE, RAM enables drop
//   asynchronously, no completion pulse issued.
// CONFIGURATION
//  ARB_FAIR_EN defined: fair_cnt (clog2(FAIR_LIMIT+1) bits) increments on each
//   DGRANT entry while iREN=1; clears on IGRANT entry or when iREN=0 in IDLE.
//   In IDLE with fair_cnt==FAIR_LIMIT and iREN=1 -> IGRANT even if dREN|dWEN.
//   Counter saturates, never wraps.
//  ARB_FAIR_EN undefined: strict dcache priority, no counter (icache may starve).
// TESTING
//  1 RST=1 mid-DGRANT, release -> state IDLE, ramWEN=0, dwait=iwait=1.
//  2 iREN=1 iaddr=0x40, RAM ACCESS 2 cycles after grant, ramload=0x8C010004
//    -> ramREN=1 ramaddr=0x40, iwait=0 for 1 cycle, iload=0x8C010004.
//  3 iREN and dWEN same cycle, daddr=0x100 dstore=0xDEADBEEF -> DGRANT first,
//    ramWEN=1 ramstore=0xDEADBEEF; then IDLE bubble, then IGRANT.
//  4 ramstate=ERROR 3 cycles then ACCESS during DGRANT (dREN) -> dwait=1
//    throughout ERROR, single dwait=0 on ACCESS.
//  5 IGRANT, iREN drops before ACCESS -> ramREN=0 same cycle, IDLE next, no iwait=0.
//  6 ARB_FAIR_EN, FAIR_LIMIT=4, dREN and iREN held high -> 4 D completions,
//    5th grant is IGRANT; without macro all grants are D.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-ported RAM to either icache or dcache (dcache priority)
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   iREN, iaddr -> iwait, iload   icache read request and handshake
//   dREN, dWEN, daddr, dstore     dcache request (write wins when both are set)
//   dwait, dload                  dcache handshake
//   ramREN, ramWEN, ramaddr,      RAM request side, driven only while a grant is held
//   ramstore
//   ramload, ramstate             RAM read data and status (FREE/BUSY/ACCESS/ERROR)
// Optional feature: define ARB_FAIR_EN to force an icache turn after FAIR_LIMIT
// consecutive dcache grants while iREN is pending.
module mem_arbiter #(
  parameter int WORD_W = 32,
  parameter int FAIR_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);
  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
  localparam logic [1:0] ACCESS = 2'd2;
  state_t state, next;
  logic fair_take;
  logic d_req;
  assign d_req = dREN | dWEN;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= next;
`ifdef ARB_FAIR_EN
  localparam int CW = $clog2(FAIR_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(FAIR_LIMIT);
  logic [CW-1:0] fair_cnt;
  assign fair_take = iREN && fair_cnt == LIM;
  // Counts dcache grants taken while the icache is waiting; saturates at LIM.
  always_ff @(posedge CLK or posedge RST)
    if (RST) fair_cnt <= '0;
    else if (state == IDLE) begin
      if (!iREN || next == IGRANT) fair_cnt <= '0;
      else if (next == DGRANT && fair_cnt != LIM) fair_cnt <= fair_cnt + 1'b1;
    end
`else
  // Strict dcache priority: the icache is never handed a forced turn.
  assign fair_take = FAIR_LIMIT < 0;
`endif
  always_comb begin
    next = state;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    iwait = 1'b1;
    dwait = 1'b1;
    iload = '0;
    dload = '0;
    case (state)
      IDLE: next = fair_take ? IGRANT : d_req ? DGRANT : iREN ? IGRANT : IDLE;
      DGRANT: begin
        ramaddr = daddr;
        ramstore = dstore;
        ramWEN = dWEN;
        ramREN = dREN & ~dWEN;
        // A withdrawn request ends the grant without a completion pulse.
        if (!d_req) next = IDLE;
        else if (ramstate == ACCESS) begin
          dwait = 1'b0;
          dload = ramload;
          next = IDLE;
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN = iREN;
        if (!iREN) next = IDLE;
        else if (ramstate == ACCESS) begin
          iwait = 1'b0;
          iload = ramload;
          next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, corner sequences and a randomized reference model for mem_arbiter
module tb_mem_arbiter;
  localparam int W = 32;
  localparam int LIM = 4;
  localparam logic [W-1:0] IA = 32'h40, DA = 32'h100, DS = 32'hDEADBEEF, RL = 32'h8C010004;
  logic CLK = 1'b0;
  logic RST;
  logic iREN, dREN, dWEN;
  logic [W-1:0] iaddr, daddr, dstore, ramload;
  logic [1:0] ramstate;
  logic iwait, dwait, ramREN, ramWEN;
  logic [W-1:0] iload, dload, ramaddr, ramstore;
  logic [131:0] act;
  int n_cmp = 0;
  int n_bad = 0;
  mem_arbiter #(.WORD_W(W), .FAIR_LIMIT(LIM)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );
  always #5 CLK = ~CLK;
  assign act = {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload};
  typedef struct {
    logic i_ren, d_ren, d_wen;
    logic [1:0] rs;
    logic [131:0] exp;
  } vec_t;
  function automatic logic [131:0] pk(input logic iw, dw, rr, rw, input logic [W-1:0] a, s, il, dl);
    return {iw, dw, rr, rw, a, s, il, dl};
  endfunction
  function automatic vec_t v(input logic i, dr, dw, input logic [1:0] rs, input logic [131:0] e);
    vec_t r;
    r.i_ren = i;
    r.d_ren = dr;
    r.d_wen = dw;
    r.rs = rs;
    r.exp = e;
    return r;
  endfunction
  task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic drive(input logic i, dr, dw, input logic [1:0] rs);
    iREN = i;
    dREN = dr;
    dWEN = dw;
    ramstate = rs;
  endtask
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    drive(0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b0;
  endtask
  vec_t tbl[$];
  logic [131:0] idle_o, ig_busy, ig_done, dg_rd, dg_rd_done, dg_wr_done;
  int owner, streak, seen;
  logic [4:0] i_done;
  logic [131:0] e;
  initial begin
    idle_o = pk(1, 1, 0, 0, 0, 0, 0, 0);
    ig_busy = pk(1, 1, 1, 0, IA, 0, 0, 0);
    ig_done = pk(0, 1, 1, 0, IA, 0, RL, 0);
    dg_rd = pk(1, 1, 1, 0, DA, DS, 0, 0);
    dg_rd_done = pk(1, 0, 1, 0, DA, DS, 0, RL);
    dg_wr_done = pk(1, 0, 0, 1, DA, DS, 0, RL);
    tbl.push_back(v(0, 0, 0, 0, idle_o));
    tbl.push_back(v(1, 0, 0, 0, idle_o));
    tbl.push_back(v(1, 0, 0, 1, ig_busy));
    tbl.push_back(v(1, 0, 0, 1, ig_busy));
    tbl.push_back(v(1, 0, 0, 2, ig_done));
    tbl.push_back(v(0, 0, 0, 0, idle_o));
    tbl.push_back(v(1, 0, 1, 0, idle_o));
    tbl.push_back(v(1, 0, 1, 2, dg_wr_done));
    tbl.push_back(v(1, 0, 0, 0, idle_o));
    tbl.push_back(v(1, 0, 0, 2, ig_done));
    tbl.push_back(v(0, 0, 0, 0, idle_o));
    tbl.push_back(v(0, 1, 0, 0, idle_o));
    tbl.push_back(v(0, 1, 0, 3, dg_rd));
    tbl.push_back(v(0, 1, 0, 3, dg_rd));
    tbl.push_back(v(0, 1, 0, 3, dg_rd));
    tbl.push_back(v(0, 1, 0, 2, dg_rd_done));
    tbl.push_back(v(0, 0, 0, 0, idle_o));
    tbl.push_back(v(1, 0, 0, 0, idle_o));
    tbl.push_back(v(1, 0, 0, 1, ig_busy));
    tbl.push_back(v(0, 0, 0, 1, pk(1, 1, 0, 0, IA, 0, 0, 0)));
    tbl.push_back(v(0, 0, 0, 2, idle_o));
    RST = 1'b1;
    iaddr = IA;
    daddr = DA;
    dstore = DS;
    ramload = RL;
    drive(0, 0, 0, 0);
    #12;
    check("reset_state", act, idle_o);
    @(negedge CLK);
    RST = 1'b0;
    foreach (tbl[k]) begin
      drive(tbl[k].i_ren, tbl[k].d_ren, tbl[k].d_wen, tbl[k].rs);
      #1;
      check($sformatf("vec%0d", k), act, tbl[k].exp);
      @(negedge CLK);
    end
    drive(0, 0, 1, 1);
    @(negedge CLK);
    #1;
    check("rst_pre_dgrant", act, pk(1, 1, 0, 1, DA, DS, 0, 0));
    RST = 1'b1;
    #1;
    check("rst_async_drop", act, idle_o);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_release_idle", act, idle_o);
    do_reset();
    drive(1, 1, 0, 2);
    seen = 0;
    i_done = '0;
    for (int c = 0; c < 20 && seen < 5; c++) begin
      #1;
      if (!iwait || !dwait) begin
        i_done[seen] = !iwait;
        seen++;
      end
      @(negedge CLK);
    end
    check("fair_count", 132'(seen), 132'(5));
`ifdef ARB_FAIR_EN
    check("fair_order", 132'(i_done), 132'(5'b10000));
`else
    check("fair_order", 132'(i_done), 132'(5'b00000));
`endif
    do_reset();
    owner = 0;
    streak = 0;
    for (int c = 0; c < 3000; c++) begin
      iREN = $urandom_range(0, 3) != 0;
      dREN = $urandom_range(0, 1) != 0;
      dWEN = $urandom_range(0, 3) == 0;
      ramstate = $urandom_range(0, 1) != 0 ? 2'd2 : 2'($urandom_range(0, 3));
      iaddr = $urandom;
      daddr = $urandom;
      dstore = $urandom;
      ramload = $urandom;
      #1;
      e = idle_o;
      if (owner == 1) e = pk(!(iREN && ramstate == 2), 1, iREN, 0, iaddr, 0,
                             (iREN && ramstate == 2) ? ramload : 0, 0);
      if (owner == 2) e = pk(1, !((dREN || dWEN) && ramstate == 2), dREN && !dWEN, dWEN, daddr, dstore,
                             0, ((dREN || dWEN) && ramstate == 2) ? ramload : 0);
      check($sformatf("rand%0d", c), act, e);
      if (owner == 0) begin
`ifdef ARB_FAIR_EN
        owner = (iREN && streak == LIM) ? 1 : (dREN || dWEN) ? 2 : iREN ? 1 : 0;
`else
        owner = (dREN || dWEN) ? 2 : iREN ? 1 : 0;
`endif
        streak = (!iREN || owner == 1) ? 0 : (owner == 2 && streak < LIM) ? streak + 1 : streak;
      end else if (owner == 1) owner = (!iREN || ramstate == 2) ? 0 : 1;
      else owner = (!(dREN || dWEN) || ramstate == 2) ? 0 : 2;
      @(negedge CLK);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
